// File: rtl/pic_bus_pkg.sv
// Shared encodings for the 8259 PIC bus master.
// Op codes, FSM states and phase counter width.
package pic_bus_pkg;

  localparam int PH_W = 4;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_INTA = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP,
    S_RECOVER
  } state_t;

endpackage

// File: rtl/pic_bus_master.sv
// CPU-side 8080/8086-style bus cycle initiator for the 8259 PIC.
// Turns single-beat write/read/inta requests into registered bus cycles.
module pic_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 2,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned INTA_GAP_CYC = 2,
  parameter int unsigned RECOVERY_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  inout  wire  [7:0] Data,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A0,
  output logic       INTA_n
);

  state_t          state_q, state_d;
  logic [PH_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            ra0_q, ra0_d;
  logic [7:0]      wd_q, wd_d;
  logic            second_q, second_d;

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       inta_n_q, inta_n_d;
  logic       a0_q, a0_d;
  logic       oe_q, oe_d;
  logic       rv_q, rv_d;
  logic       re_q, re_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ready_q, ready_d;

  logic accept;
  logic bus_cyc;
  logic strobe;
  logic cap;

  assign accept = req_valid & ready_q;

  function automatic logic [PH_W-1:0] ph_len(input state_t s);
    logic [PH_W-1:0] r;
    r = '0;
    unique case (s)
      S_SETUP:   r = PH_W'(SETUP_CYC - 1);
      S_STROBE:  r = PH_W'(STROBE_CYC - 1);
      S_HOLD:    r = PH_W'(HOLD_CYC - 1);
      S_GAP:     r = PH_W'(INTA_GAP_CYC - 1);
      S_RECOVER: r = PH_W'(RECOVERY_CYC - 1);
      default:   r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_WR;
      ra0_q    <= 1'b0;
      wd_q     <= '0;
      second_q <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      inta_n_q <= 1'b1;
      a0_q     <= 1'b0;
      oe_q     <= 1'b0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ra0_q    <= ra0_d;
      wd_q     <= wd_d;
      second_q <= second_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      inta_n_q <= inta_n_d;
      a0_q     <= a0_d;
      oe_q     <= oe_d;
      rv_q     <= rv_d;
      re_q     <= re_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra0_d    = ra0_q;
    wd_d     = wd_q;
    second_d = second_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = req_op;
          ra0_d    = req_a0;
          wd_d     = req_wdata;
          second_d = 1'b0;
          state_d  = (req_op == OP_ILL) ? S_RECOVER : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (op_q == OP_INTA && !second_q) state_d = S_GAP;
          else state_d = S_RECOVER;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d  = S_STROBE;
          second_d = 1'b1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = ph_len(state_d);
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    else cnt_d = cnt_q;
  end

  // Pin values are derived from the next state so they leave flops.
  always_comb begin
    bus_cyc  = (state_d == S_SETUP) || (state_d == S_STROBE)
            || (state_d == S_HOLD);
    strobe   = (state_d == S_STROBE);
    cs_n_d   = !(bus_cyc && op_d != OP_INTA);
    a0_d     = !cs_n_d & ra0_d;
    oe_d     = bus_cyc && op_d == OP_WR;
    wr_n_d   = !(strobe && op_d == OP_WR);
    rd_n_d   = !(strobe && op_d == OP_RD);
    inta_n_d = !(strobe && op_d == OP_INTA);
    rv_d     = (state_d == S_RECOVER) && (state_q != S_RECOVER);
    re_d     = rv_d && op_d == OP_ILL;
    cap      = (state_q == S_STROBE) && (cnt_q == '0)
            && (op_q == OP_RD || (op_q == OP_INTA && second_q));
    rdata_d  = cap ? Data : rdata_q;
    ready_d  = (state_d == S_IDLE);
  end

  assign Data      = oe_q ? wd_q : 8'bz;
  assign CS_n      = cs_n_q;
  assign RD_n      = rd_n_q;
  assign WR_n      = wr_n_q;
  assign INTA_n    = inta_n_q;
  assign A0        = a0_q;
  assign req_ready = ready_q;
  assign rsp_valid = rv_q;
  assign rsp_err   = re_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Scoreboard bench for pic_bus_master with a small PIC responder.
// Undriven bus is pulled up, so a released bus reads 8'hFF.
module tb_pic_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic       req_a0 = 1'b0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  wire  [7:0] Data;
  logic       CS_n, RD_n, WR_n, A0, INTA_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int inta_cnt = 0;
  int k;

  logic       drv_en;
  logic [7:0] drv_val;

  typedef struct {
    int         edge_no;
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  pic_bus_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a0(req_a0), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .Data(Data), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .A0(A0), .INTA_n(INTA_n)
  );

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (Data[g]);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge INTA_n) inta_cnt <= inta_cnt + 1;

  always_comb begin
    drv_en  = !RD_n || !INTA_n;
    drv_val = 8'hA5;
    if (!INTA_n) drv_val = (inta_cnt == 1) ? 8'hFF : 8'h48;
  end
  assign Data = drv_en ? drv_val : 8'bz;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: cycle n of a transaction is sampled between edges n-1 and n.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e.edge_no);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic a0,
                       input logic [7:0] wd, input int lat,
                       input logic eerr, input logic [7:0] erd,
                       input bit want_rsp);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a0    = a0;
    req_wdata = wd;
    @(posedge clk);
    #1;
    k = cyc;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a0    = 1'b0;
    req_wdata = 8'h00;
    if (want_rsp) begin
      e.edge_no = k + lat - 1;
      e.err     = eerr;
      e.rdata   = erd;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("rsp_pending", exp_q.size(), 0);
  endtask

  initial begin
    #12;
    check("rst_cs", {31'd0, CS_n}, 1);
    check("rst_strobes", {29'd0, RD_n, WR_n, INTA_n}, 3'b111);
    check("rst_a0", {31'd0, A0}, 0);
    check("rst_data", {24'd0, Data}, 8'hFF);
    check("rst_ready", {31'd0, req_ready}, 0);
    check("rst_rsp", {31'd0, rsp_valid}, 0);
    check("rst_rdata", {24'd0, rsp_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", {31'd0, req_ready}, 1);

    // Write ICW1
    issue(2'd0, 1'b0, 8'h13, 5, 1'b0, 8'h00, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check($sformatf("wr_cs_%0d", j), {31'd0, CS_n},
            (j >= 1 && j <= 4) ? 0 : 1);
      check($sformatf("wr_wr_%0d", j), {31'd0, WR_n},
            (j >= 2 && j <= 3) ? 0 : 1);
      check($sformatf("wr_data_%0d", j), {24'd0, Data},
            (j <= 4) ? 8'h13 : 8'hFF);
      check($sformatf("wr_rdinta_%0d", j), {30'd0, RD_n, INTA_n}, 2'b11);
      if (j >= 5)
        check($sformatf("wr_ready_%0d", j), {31'd0, req_ready},
              (j == 6) ? 1 : 0);
    end
    wait_idle();

    // Read with A0=1; master must never drive the bus
    issue(2'd1, 1'b1, 8'hC3, 5, 1'b0, 8'hA5, 1'b1);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("rd_rd_%0d", j), {31'd0, RD_n},
            (j >= 2 && j <= 3) ? 0 : 1);
      check($sformatf("rd_a0_%0d", j), {31'd0, A0}, (j <= 4) ? 1 : 0);
      check($sformatf("rd_data_%0d", j), {24'd0, Data},
            (j >= 2 && j <= 3) ? 8'hA5 : 8'hFF);
      check($sformatf("rd_wr_%0d", j), {31'd0, WR_n}, 1);
    end
    wait_idle();

    // Interrupt acknowledge: two pulses, second carries the vector
    issue(2'd2, 1'b1, 8'h00, 10, 1'b0, 8'h48, 1'b1);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      check($sformatf("inta_n_%0d", j), {31'd0, INTA_n},
            (j == 2 || j == 3 || j == 7 || j == 8) ? 0 : 1);
      check($sformatf("inta_cs_%0d", j), {31'd0, CS_n}, 1);
      check($sformatf("inta_rdwr_%0d", j), {30'd0, RD_n, WR_n}, 2'b11);
    end
    wait_idle();

    // Illegal op: error pulse next cycle, no bus activity
    issue(2'd3, 1'b0, 8'h77, 1, 1'b1, 8'h48, 1'b1);
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      check($sformatf("ill_pins_%0d", j),
            {28'd0, CS_n, RD_n, WR_n, INTA_n}, 4'b1111);
      check($sformatf("ill_data_%0d", j), {24'd0, Data}, 8'hFF);
      check($sformatf("ill_ready_%0d", j), {31'd0, req_ready},
            (j == 2) ? 1 : 0);
    end
    wait_idle();

    // Reset in the middle of a write strobe
    issue(2'd0, 1'b0, 8'h3C, 5, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    check("mid_wr_low", {31'd0, WR_n}, 0);
    rst_n = 1'b0;
    #1;
    check("mid_wr_rise", {31'd0, WR_n}, 1);
    check("mid_cs_rise", {31'd0, CS_n}, 1);
    check("mid_data_z", {24'd0, Data}, 8'hFF);
    check("mid_ready", {31'd0, req_ready}, 0);
    check("mid_rdata", {24'd0, rsp_rdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 1);
    issue(2'd0, 1'b1, 8'h55, 5, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("post_wr_a0", {31'd0, A0}, 1);
    check("post_wr_data", {24'd0, Data}, 8'h55);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
